posit_pack_stream: RTL and testbench

POSIT_PACK_STREAM -- requirements
Module: posit_pack_stream

---
 rtl/posit_pack_stream.sv | 214 +++++++++++++++++++++
 tb/tb_posit_pack_stream.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_pack_stream.sv
// posit_pack_stream: packs sign/scale/fraction lanes into es=2 posits (1x32, 2x16, 4x8)
// through a 2-stage valid/ready pipeline. Define POSIT_PACK_SAT_CNT_EN to add sat_cnt.
module posit_pack_stream (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pre,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_sign,
  input  logic [31:0] in_scale,
  input  logic [31:0] in_frac,
  input  logic [3:0]  in_sticky,
  input  logic [3:0]  in_zero,
  input  logic [3:0]  in_nar,
`ifdef POSIT_PACK_SAT_CNT_EN
  output logic [15:0] sat_cnt,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_sat
);

  typedef enum logic [1:0] {MODE_P32 = 2'd0, MODE_P16 = 2'd1, MODE_P8 = 2'd2} mode_e;

  // Unrounded lane: top n-1 magnitude bits after the sign, plus round bits.
  typedef struct packed {
    logic        sat;
    logic        guard;
    logic        sticky;
    logic [30:0] mag;
  } lane_t;

  // Regime k = floor(scale/4); lanes with |k| beyond n-2 clamp to maxpos/minpos.
  function automatic lane_t build_lane(input logic [7:0] scale, input logic [31:0] frac,
                                       input logic stk, input logic [5:0] n);
    lane_t              res;
    logic signed [5:0]  k;
    logic signed [6:0]  kx;
    logic signed [6:0]  kmax;
    logic [4:0]         r;
    logic signed [71:0] body;
    logic [71:0]        low_mask;
    logic [6:0]         gpos;
    res  = '0;
    k    = 6'(signed'(scale) >>> 2);
    kx   = 7'(k);
    kmax = signed'(7'(n) - 7'd2);
    // "10"/"01" seed sign-extended by r gives k+1 ones or -k zeros before the terminator.
    r        = k[5] ? ~k[4:0] : k[4:0];
    body     = {(k[5] ? 2'b01 : 2'b10), scale[1:0], frac, 36'd0};
    body     = body >>> r;
    gpos     = 7'd72 - {1'b0, n};
    low_mask = (72'd1 << gpos) - 72'd1;
    res.mag    = 31'(unsigned'(body) >> (gpos + 7'd1));
    res.guard  = body[gpos];
    res.sticky = stk | (|(body & low_mask));
    if (kx > kmax) begin
      res     = '0;
      res.sat = 1'b1;
      res.mag = 31'((32'd1 << (n - 6'd1)) - 32'd1);
    end else if (kx < -kmax) begin
      res     = '0;
      res.sat = 1'b1;
      res.mag = 31'd1;
    end
    return res;
  endfunction

  function automatic logic [31:0] finish_lane(input lane_t l, input logic sgn, input logic zero,
                                              input logic nar, input logic [5:0] n);
    logic [31:0] mask;
    logic [31:0] mag;
    logic [31:0] res;
    mask = 32'((33'd1 << n) - 33'd1);
    mag  = {1'b0, l.mag} + {31'd0, l.guard & (l.mag[0] | l.sticky)};
    res  = sgn ? (~mag + 32'd1) : mag;
    if (nar)       res = 32'd1 << (n - 6'd1);
    else if (zero) res = '0;
    return res & mask;
  endfunction

  mode_e       mode_in;
  logic        s2_adv;
  logic        in_fire;

  logic        s1_valid_q, s1_valid_d;
  mode_e       s1_mode_q, s1_mode_d;
  lane_t [3:0] s1_lane_q, s1_lane_d;
  logic [3:0]  s1_sign_q, s1_sign_d;
  logic [3:0]  s1_zero_q, s1_zero_d;
  logic [3:0]  s1_nar_q, s1_nar_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_sat_q, out_sat_d;

  assign mode_in  = (pre == 2'b00) ? MODE_P32 : (pre == 2'b01) ? MODE_P16 : MODE_P8;
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  always_comb begin : stage1_comb
    // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_lane_d  = s1_lane_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_nar_d   = s1_nar_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_fire) begin
      s1_mode_d = mode_in;
      s1_sign_d = in_sign;
      s1_lane_d = '0;
      // Unused lanes are flagged zero so they pack to 0 with no sat.
      unique case (mode_in)
        MODE_P32: begin
          s1_lane_d[0] = build_lane(in_scale[7:0], in_frac, in_sticky[0], 6'd32);
          s1_zero_d    = {3'b111, in_zero[0]};
          s1_nar_d     = {3'b000, in_nar[0]};
        end
        MODE_P16: begin
          for (int j = 0; j < 2; j++)
            s1_lane_d[j] = build_lane(in_scale[8*j +: 8], {in_frac[16*j +: 16], 16'd0},
                                      in_sticky[j], 6'd16);
          s1_zero_d = {2'b11, in_zero[1:0]};
          s1_nar_d  = {2'b00, in_nar[1:0]};
        end
        default: begin
          for (int j = 0; j < 4; j++)
            s1_lane_d[j] = build_lane(in_scale[8*j +: 8], {in_frac[8*j +: 8], 24'd0},
                                      in_sticky[j], 6'd8);
          s1_zero_d = in_zero;
          s1_nar_d  = in_nar;
        end
      endcase
    end
  end

  always_comb begin : stage2_comb
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = '0;
        unique case (s1_mode_q)
          MODE_P32: out_data_d = finish_lane(s1_lane_q[0], s1_sign_q[0], s1_zero_q[0],
                                             s1_nar_q[0], 6'd32);
          MODE_P16: begin
            for (int j = 0; j < 2; j++)
              out_data_d[16*j +: 16] = 16'(finish_lane(s1_lane_q[j], s1_sign_q[j],
                                                       s1_zero_q[j], s1_nar_q[j], 6'd16));
          end
          default: begin
            for (int j = 0; j < 4; j++)
              out_data_d[8*j +: 8] = 8'(finish_lane(s1_lane_q[j], s1_sign_q[j],
                                                    s1_zero_q[j], s1_nar_q[j], 6'd8));
          end
        endcase
        for (int j = 0; j < 4; j++)
          out_sat_d[j] = s1_lane_q[j].sat & ~s1_zero_q[j] & ~s1_nar_q[j];
      end
    end
  end

  // NOTE: sequential state uses <= only; payload flops take the reset too so outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_P32;
      s1_lane_q   <= '0;
      s1_sign_q   <= '0;
      s1_zero_q   <= '0;
      s1_nar_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_lane_q   <= s1_lane_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_nar_q    <= s1_nar_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

`ifdef POSIT_PACK_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (out_valid_q && out_ready && (|out_sat_q) && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_posit_pack_stream.sv
// Self-checking bench for posit_pack_stream: directed vectors plus a randomized stream
// scored against a bit-queue posit encoder. Covers sat_cnt when POSIT_PACK_SAT_CNT_EN is set.
`timescale 1ns/1ps
module tb_posit_pack_stream;

  typedef struct packed {
    logic [1:0]  pre;
    logic [3:0]  sign;
    logic [31:0] scale;
    logic [31:0] frac;
    logic [3:0]  sticky;
    logic [3:0]  zero;
    logic [3:0]  nar;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  pre = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_sign = '0;
  logic [31:0] in_scale = '0;
  logic [31:0] in_frac = '0;
  logic [3:0]  in_sticky = '0;
  logic [3:0]  in_zero = '0;
  logic [3:0]  in_nar = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_sat;
`ifdef POSIT_PACK_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  int    checks = 0;
  int    failures = 0;
  int    delivered = 0;
  int    exp_cnt = 0;
  beat_t pend[$];
  exp_t  sb[$];

  posit_pack_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pre      (pre),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_scale (in_scale),
    .in_frac  (in_frac),
    .in_sticky(in_sticky),
    .in_zero  (in_zero),
    .in_nar   (in_nar),
`ifdef POSIT_PACK_SAT_CNT_EN
    .sat_cnt  (sat_cnt),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoder: writes out the posit bit string, then rounds the first n-1 bits.
  function automatic void ref_lane(input bit sgn, input int scale, input longint unsigned frac,
                                   input bit stk, input bit zero, input bit nar, input int n,
                                   output longint unsigned val, output bit sat);
    bit q[$];
    int k;
    int e;
    longint unsigned mag;
    bit guard;
    bit rest;
    val = 0;
    sat = 0;
    if (nar) begin
      val = 64'd1 << (n - 1);
      return;
    end
    if (zero) return;
    k = (scale >= 0) ? scale / 4 : -((3 - scale) / 4);
    e = scale - 4 * k;
    if (k > n - 2) begin
      mag = (64'd1 << (n - 1)) - 1;
      sat = 1;
    end else if (k < -(n - 2)) begin
      mag = 1;
      sat = 1;
    end else begin
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = n - 1; i >= 0; i--) q.push_back(frac[i]);
      mag = 0;
      for (int i = 0; i < n - 1; i++) mag = (mag << 1) | ((i < q.size()) ? 64'(q[i]) : 64'd0);
      guard = (q.size() > n - 1) ? q[n-1] : 1'b0;
      rest  = stk;
      for (int i = n; i < q.size(); i++) rest |= q[i];
      if (guard && (mag[0] || rest)) mag++;
    end
    val = sgn ? (((64'd1 << n) - mag) & ((64'd1 << n) - 1)) : mag;
  endfunction

  function automatic exp_t model(input beat_t b);
    exp_t            r;
    int              n;
    longint unsigned v;
    bit              s;
    r = '0;
    n = (b.pre == 2'b00) ? 32 : (b.pre == 2'b01) ? 16 : 8;
    for (int i = 0; i < 32 / n; i++) begin
      ref_lane(b.sign[i], int'(signed'(b.scale[8*i +: 8])),
               (64'(b.frac) >> (n * i)) & ((64'd1 << n) - 1),
               b.sticky[i], b.zero[i], b.nar[i], n, v, s);
      r.data   = r.data | 32'(v << (n * i));
      r.sat[i] = s;
    end
    return r;
  endfunction

  function automatic beat_t mk(input logic [1:0] p, input logic [3:0] sg, input logic [31:0] sc,
                               input logic [31:0] fr, input logic [3:0] st, input logic [3:0] z,
                               input logic [3:0] na);
    beat_t b;
    b.pre = p; b.sign = sg; b.scale = sc; b.frac = fr; b.sticky = st; b.zero = z; b.nar = na;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.pre  = 2'($urandom_range(0, 3));
    b.sign = 4'($urandom);
    for (int i = 0; i < 4; i++)
      b.scale[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                       : 8'(int'($urandom_range(0, 56)) - 28);
    b.frac   = $urandom;
    b.sticky = 4'($urandom);
    b.zero   = 4'($urandom & $urandom & $urandom);
    b.nar    = 4'($urandom & $urandom & $urandom & $urandom);
    return b;
  endfunction

  task automatic drive(input beat_t b);
    pre = b.pre; in_sign = b.sign; in_scale = b.scale; in_frac = b.frac;
    in_sticky = b.sticky; in_zero = b.zero; in_nar = b.nar;
  endtask

  // One clock: offer the head of pend, score any delivered beat, enqueue any accepted beat.
  task automatic cycle();
    exp_t  e;
    beat_t b;
    if (pend.size() > 0) begin
      drive(pend[0]);
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("stream_data", out_data, e.data);
        check("stream_sat", 32'(out_sat), 32'(e.sat));
        if (e.sat != 4'd0) exp_cnt++;
        delivered++;
      end
    end
    if (in_valid && in_ready) begin
      b = pend.pop_front();
      sb.push_back(model(b));
    end
    @(posedge clk); #1;
  endtask

  // Single beat with out_ready high: checks latency and a fixed expected result.
  task automatic run_single(input string tag, input beat_t b, input logic [31:0] exp_d,
                            input logic [3:0] exp_s);
    drive(b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_not_yet_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
    if (exp_s != 4'd0) exp_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    int start;
    int budget;

    #2 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef POSIT_PACK_SAT_CNT_EN
    check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_single("p32_one",    mk(2'b00, 4'h0, 32'h0,        32'h0,        4'h0, 4'h0, 4'h0), 32'h40000000, 4'h0);
    run_single("p32_scale1", mk(2'b00, 4'h0, 32'h1,        32'h0,        4'h0, 4'h0, 4'h0), 32'h48000000, 4'h0);
    run_single("p32_frac",   mk(2'b00, 4'h0, 32'h0,        32'h80000000, 4'h0, 4'h0, 4'h0), 32'h44000000, 4'h0);
    run_single("p16_neg_nar", mk(2'b01, 4'h1, 32'h0,       32'h0,        4'h0, 4'h0, 4'h2), 32'h8000C000, 4'h0);
    run_single("p8_tie_even", mk(2'b10, 4'h0, 32'h0,       32'h10,       4'h0, 4'h0, 4'h0), 32'h40404040, 4'h0);
    run_single("p8_tie_up",   mk(2'b10, 4'h0, 32'h0,       32'h30,       4'h0, 4'h0, 4'h0), 32'h40404042, 4'h0);
    run_single("p8_sticky",   mk(2'b11, 4'h0, 32'h0,       32'h10,       4'h1, 4'h0, 4'h0), 32'h40404041, 4'h0);
    run_single("p8_maxpos",   mk(2'b10, 4'h0, 32'h00640000, 32'h0,       4'h0, 4'h0, 4'h0), 32'h407F4040, 4'h4);
    run_single("p8_minpos",   mk(2'b10, 4'h0, 32'h009C0000, 32'h0,       4'h0, 4'h0, 4'h0), 32'h40014040, 4'h4);
    run_single("p16_zero",    mk(2'b01, 4'h3, 32'h0,       32'hFFFFFFFF, 4'h0, 4'h3, 4'h0), 32'h00000000, 4'h0);
`ifdef POSIT_PACK_SAT_CNT_EN
    check("sat_cnt_directed", 32'(sat_cnt), 32'(exp_cnt));
`endif

    // Backpressure: stall the consumer, fill both stages, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pend.push_back(rand_beat());
    repeat (3) cycle();
    check("bp_accepted", 32'(sb.size()), 32'd2);
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    repeat (2) cycle();
    check("bp_still_two", 32'(sb.size()), 32'd2);
    check("bp_hold_data", out_data, sb[0].data);
    check("bp_hold_sat", 32'(out_sat), 32'(sb[0].sat));
    start     = delivered;
    out_ready = 1'b1;
    repeat (8) cycle();
    check("bp_one_per_cycle", 32'(delivered - start), 32'd8);
    check("bp_all_drained", 32'(sb.size() + pend.size()), 32'd0);
`ifdef POSIT_PACK_SAT_CNT_EN
    check("sat_cnt_bp", 32'(sat_cnt), 32'(exp_cnt));
`endif

    // Reset with two beats in flight.
    out_ready = 1'b0;
    pend.push_back(rand_beat());
    pend.push_back(rand_beat());
    repeat (2) cycle();
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_out_sat", 32'(out_sat), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef POSIT_PACK_SAT_CNT_EN
    check("mid_rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    in_valid = 1'b0;
    pend.delete();
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) begin
      cycle();
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end

    // Randomized stream with random consumer stalls.
    for (int i = 0; i < 300; i++) pend.push_back(rand_beat());
    budget = 0;
    while ((pend.size() > 0 || sb.size() > 0) && budget < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      budget++;
    end
    check("random_drain", 32'(pend.size() + sb.size()), 32'd0);
`ifdef POSIT_PACK_SAT_CNT_EN
    check("sat_cnt_final", 32'(sat_cnt), 32'(exp_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
